// File: rtl/vec_rf_pkg.sv
// Shared definitions for the vector register-file sequencer.
//
// Holds the block configuration, the FSM state type, the writeback-pipe entry
// type and the per-chunk byte-mask helper. Configuration lives here rather than
// in module parameters because the writeback entry type depends on it.
package vec_rf_pkg;

  localparam int VLEN       = 128;                 // vector length in bits
  localparam int DATA_WIDTH = 64;                  // register-file port width in bits
  localparam int DW_B       = DATA_WIDTH / 8;      // port width in bytes
  localparam int ADDR_WIDTH = 5;                   // vector register address bits
  localparam int OFF_BITS   = 8;                   // chunk offset bits
  localparam int ALU_LAT    = 2;                   // read data to ALU result, cycles (>= 1)
  localparam int VLEN_B     = VLEN / 8;            // vector length in bytes
  localparam int VLB_W      = $clog2(VLEN_B) + 1;  // byte-count field width

  localparam int NCHUNK   = VLEN / DATA_WIDTH;     // chunks in a full vector
  localparam int WB_DEPTH = 1 + ALU_LAT;           // read issue to writeback, cycles

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] vd;
    logic [OFF_BITS-1:0]   off;
    logic [DW_B-1:0]       mask;
    logic                  last;
  } wb_entry_t;

  // Byte j of chunk k is active when its absolute byte index is below vl.
  function automatic logic [DW_B-1:0] byte_mask(input logic [OFF_BITS-1:0] k,
                                                 input logic [VLB_W-1:0]    vl);
    logic [DW_B-1:0] m;
    m = '0;
    for (int j = 0; j < DW_B; j++) begin
      m[j] = (int'(k) * DW_B + j) < int'(vl);
    end
    return m;
  endfunction

endpackage

// File: rtl/vec_rf_wb_pipe.sv
// Writeback delay line: a shift register of wb_entry_t that carries the
// destination register, chunk offset and byte mask from read issue to the cycle
// the ALU result is ready. Each stage also reports whether its destination
// matches either of two compare addresses, for RAW hazard detection.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push           entry entering stage 0 this cycle (valid=0 for a bubble)
//   cmp_a, cmp_b   source registers to compare against each stage's vd
//   head           oldest stage, drives writeback
//   hit            per-stage: stage valid and vd equals cmp_a or cmp_b
//   any_valid      at least one stage holds a valid entry
module vec_rf_wb_pipe
  import vec_rf_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  wb_entry_t             push,
  input  logic [ADDR_WIDTH-1:0] cmp_a,
  input  logic [ADDR_WIDTH-1:0] cmp_b,
  output wb_entry_t             head,
  output logic [DEPTH-1:0]      hit,
  output logic                  any_valid
);

  wb_entry_t stage_q [DEPTH];

  // NOTE: this array is pipeline control state, not storage, so every stage is
  // reset; a stale valid bit would otherwise raise write enables after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's old value, which is what turns this into a shift.
      stage_q[0] <= push;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head = stage_q[DEPTH-1];

  always_comb begin
    // NOTE: defaults first so no path through the block leaves an output
    // unassigned, which would otherwise infer a latch.
    hit       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i]    = stage_q[i].valid && (stage_q[i].vd == cmp_a || stage_q[i].vd == cmp_b);
      any_valid = any_valid | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/vec_rf_seq.sv
// Sequencer and port arbiter in front of the vector register file.
//
// Accepts one vector-vector op, issues one DATA_WIDTH chunk read per cycle on
// both read ports, delays the destination through the writeback pipe so it
// lines up with the ALU result, and gates the load writeback port so a load is
// never dropped by an address clash with the ALU writeback.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              op handshake
//   req_vs1, req_vs2, req_vd         source / destination registers
//   req_vl_bytes                     active bytes, clamped to VLEN/8
//   rd_en_*, rd_addr_*, rd_off_*     read ports 1 and 2 (offsets always equal)
//   alu_valid                        read data valid this cycle
//   wr_en, wr_addr, wr_off           ALU writeback port
//   ld_valid, ld_addr_in, ld_be      load-unit writeback request
//   ld_ready, ld_en                  load accepted / byte enables to register file
//   busy                             sequencing or writebacks in flight
//   done                             pulse with the last writeback of an op
module vec_rf_seq
  import vec_rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_vs1,
  input  logic [ADDR_WIDTH-1:0] req_vs2,
  input  logic [ADDR_WIDTH-1:0] req_vd,
  input  logic [VLB_W-1:0]      req_vl_bytes,
  output logic [DW_B-1:0]       rd_en_1,
  output logic [DW_B-1:0]       rd_en_2,
  output logic [ADDR_WIDTH-1:0] rd_addr_1,
  output logic [ADDR_WIDTH-1:0] rd_addr_2,
  output logic [OFF_BITS-1:0]   rd_off_1,
  output logic [OFF_BITS-1:0]   rd_off_2,
  output logic                  alu_valid,
  output logic [DW_B-1:0]       wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [OFF_BITS-1:0]   wr_off,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr_in,
  input  logic [DW_B-1:0]       ld_be,
  output logic                  ld_ready,
  output logic [DW_B-1:0]       ld_en,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [OFF_BITS-1:0]   k_q, k_d;
  logic [ADDR_WIDTH-1:0] op_vs1_q, op_vs2_q, op_vd_q;
  logic [VLB_W-1:0]      op_vl_q;
  logic [OFF_BITS-1:0]   op_last_k_q;
  logic [ADDR_WIDTH-1:0] rd_addr_1_q, rd_addr_2_q;
  logic [OFF_BITS-1:0]   rd_off_q;
  logic                  alu_valid_q, zero_done_q;

  // iss_q is the read-issue register: it drives the read ports and feeds the
  // writeback pipe, so the pipe head lands 1+ALU_LAT cycles after the read.
  wb_entry_t             iss_q, iss_d, head;
  logic [WB_DEPTH-1:0]   pipe_hit;
  logic                  pipe_any;

  logic [VLB_W-1:0]      vl_clamped;
  logic [OFF_BITS-1:0]   nchunk_req;
  logic                  accept, issue, hazard, wr_active;

  assign vl_clamped = (req_vl_bytes > VLB_W'(VLEN_B)) ? VLB_W'(VLEN_B) : req_vl_bytes;
  assign nchunk_req = OFF_BITS'((int'(vl_clamped) + DW_B - 1) / DW_B);

  // A source still waiting on an earlier destination write is a RAW hazard;
  // the chunk in the issue register counts as much as those in the pipe.
  assign hazard    = |pipe_hit
                   || (iss_q.valid && (iss_q.vd == req_vs1 || iss_q.vd == req_vs2));
  assign req_ready = (state_q == IDLE) && !hazard;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (nchunk_req != '0) begin
            state_d = ISSUE;
            k_d     = '0;
          end
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (k_q == op_last_k_q) state_d = IDLE;
        else                    k_d     = k_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iss_d = '0;
    if (issue) begin
      iss_d.valid = 1'b1;
      iss_d.vd    = op_vd_q;
      iss_d.off   = k_q;
      iss_d.mask  = byte_mask(k_q, op_vl_q);
      iss_d.last  = (k_q == op_last_k_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      op_vs1_q    <= '0;
      op_vs2_q    <= '0;
      op_vd_q     <= '0;
      op_vl_q     <= '0;
      op_last_k_q <= '0;
      iss_q       <= '0;
      rd_addr_1_q <= '0;
      rd_addr_2_q <= '0;
      rd_off_q    <= '0;
      alu_valid_q <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      iss_q       <= iss_d;
      alu_valid_q <= |iss_q.mask;
      // An empty op never enters the pipe, so its completion is flagged here.
      zero_done_q <= accept && (nchunk_req == '0);
      if (accept) begin
        op_vs1_q    <= req_vs1;
        op_vs2_q    <= req_vs2;
        op_vd_q     <= req_vd;
        op_vl_q     <= vl_clamped;
        op_last_k_q <= nchunk_req - 1'b1;
      end
      if (issue) begin
        rd_addr_1_q <= op_vs1_q;
        rd_addr_2_q <= op_vs2_q;
        rd_off_q    <= k_q;
      end
    end
  end

  vec_rf_wb_pipe #(.DEPTH(WB_DEPTH)) u_wb_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (iss_q),
    .cmp_a     (req_vs1),
    .cmp_b     (req_vs2),
    .head      (head),
    .hit       (pipe_hit),
    .any_valid (pipe_any)
  );

  assign rd_en_1   = iss_q.mask;
  assign rd_en_2   = iss_q.mask;
  assign rd_addr_1 = rd_addr_1_q;
  assign rd_addr_2 = rd_addr_2_q;
  assign rd_off_1  = rd_off_q;
  assign rd_off_2  = rd_off_q;
  assign alu_valid = alu_valid_q;

  assign wr_active = head.valid && (|head.mask);
  assign wr_en     = wr_active ? head.mask : '0;
  assign wr_off    = head.valid ? head.off : '0;
  // The register file drops a load whenever wr_addr matches it, even with no
  // write enable, so an idle write port points away from the load address.
  assign wr_addr   = wr_active ? head.vd : (ld_addr_in ^ ADDR_WIDTH'(1));

  assign ld_ready  = !(wr_active && head.vd == ld_addr_in);
  assign ld_en     = (rst_n && ld_valid && ld_ready) ? ld_be : '0;

  assign busy      = (state_q != IDLE) || iss_q.valid || pipe_any;
  assign done      = (head.valid && head.last) || zero_done_q;

endmodule

// File: doc/vec_rf_seq.md
Name: vec_rf_seq

Overview:
- Sequencer and port arbiter in front of the vector register file.
- Accepts one vector-vector op (vs1, vs2, vd, active byte count) and issues DATA_WIDTH-wide chunk reads on both read ports, one chunk per cycle.
- Delays destination address, offset and byte mask to line up with ALU results for writeback.
- Gates the load writeback port so a load is never silently dropped on an address clash.

Parameters:
- VLEN, 128, vector length in bits
- DATA_WIDTH, 64, register-file port width in bits
- DW_B, DATA_WIDTH/8, port width in bytes
- ADDR_WIDTH, 5, vector register address bits
- OFF_BITS, 8, chunk offset bits
- ALU_LAT, 2, cycles from register-file read data to ALU result (≥1)
- VLB_W, $clog2(VLEN/8)+1, width of the byte-count field

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  op request
- req_ready  out  1  op accepted when valid&ready
- req_vs1, req_vs2, req_vd  in  ADDR_WIDTH each  source and destination registers
- req_vl_bytes  in  VLB_W  active bytes; clamped to VLEN/8
- rd_en_1, rd_en_2  out  DW_B  read byte enables
- rd_addr_1, rd_addr_2  out  ADDR_WIDTH  read addresses
- rd_off_1, rd_off_2  out  OFF_BITS  read chunk offsets (always equal)
- alu_valid  out  1  register-file read data valid this cycle, to ALU
- wr_en  out  DW_B  writeback byte enables, aligned to ALU result
- wr_addr  out  ADDR_WIDTH  writeback register
- wr_off  out  OFF_BITS  writeback chunk
- ld_valid  in  1  load-unit writeback request
- ld_addr_in  in  ADDR_WIDTH  load destination register
- ld_be  in  DW_B  load byte enables
- ld_ready  out  1  load write accepted this cycle
- ld_en  out  DW_B  to register file: ld_be when ld_valid&ld_ready, else 0
- busy  out  1  sequencing or writebacks in flight
- done  out  1  one-cycle pulse with the last writeback of an op

Behaviour:
- Reset, asynchronous: FSM to IDLE; writeback pipe cleared; all enables 0; all addresses and offsets 0; alu_valid, busy and done 0.
- FSM IDLE:
  - req_ready = 1 unless a RAW hazard exists. A hazard is req_vs1 or req_vs2 equal to wr-pipe vd in any valid stage, or to the current op's vd.
  - On accept: latch the op and compute nchunk = ceil(min(vl,VLEN/8)/DW_B).
  - nchunk = 0: no reads or writes; done pulses the next cycle; stay IDLE.
  - Otherwise go to ISSUE with chunk counter k = 0.
- FSM ISSUE, registered outputs, one chunk per cycle:
  - rd_addr_1 = vs1, rd_addr_2 = vs2, rd_off_* = k.
  - rd_en bit j = (k*DW_B + j) < vl; the final chunk may be partial.
  - Push {vd, k, mask, last = (k == nchunk-1)} into the writeback pipe.
  - On k == nchunk-1, return to IDLE. req_ready is 0 throughout ISSUE, giving one bubble between ops.
- Read latency is 1 cycle. alu_valid asserts one cycle after any nonzero rd_en.
- Writeback pipe is a shift register of depth 1+ALU_LAT. Its head drives wr_en, wr_addr and wr_off exactly 1+ALU_LAT cycles after the matching read issue. done pulses with the head entry whose last = 1.
- Load gating:
  - ld_ready = ~(|wr_en && wr_addr == ld_addr_in).
  - The register file drops a load whenever wr_addr equals ld_addr, even with wr_en = 0. So whenever wr_en is all-zero, wr_addr is driven to ld_addr_in ^ 1.
  - ld_ready is combinational from ld_addr_in and registered pipe state.
  - A stalled load holds its inputs; the unit retries next cycle.
- busy = (state != IDLE) | any valid pipe entry.
- Register-file reset masking is not relied upon. This block never drives enables while rst_n = 0.
- Reset mid-op: the in-flight op is abandoned and no done pulse is produced.

Decomposition:
- Shared package vec_rf_pkg holds:
  - typedef wb_entry_t {valid, vd, off, mask, last};
  - localparams NCHUNK = VLEN/DATA_WIDTH and WB_DEPTH = 1+ALU_LAT;
  - function byte_mask(k, vl).
- One natural sub-module: vec_rf_wb_pipe, the parameterized shift register of wb_entry_t with a hazard-compare output per stage.

Test Plan:
1. Defaults, vs1=1, vs2=2, vd=3, vl=16 → rd_en_* = 0xFF at off 0 then off 1 on consecutive cycles. wr_en = 0xFF, wr_addr = 3, off 0/1, exactly 3 cycles after each read. done pulses with the off-1 write.
2. vl=11 → chunk0 mask 0xFF, chunk1 mask 0x07. vl=0 → no enables, done one cycle after accept. vl=31 → clamped to 16, behaves as case 1.
3. Op A vd=5 in flight, then op B with vs1=5 → req_ready held 0 until A's last writeback leaves the pipe. Op B with vs1=6 → accepted after the single IDLE bubble.
4. ld_valid with ld_addr_in=3 while writing vd=3 → ld_ready=0 and ld_en=0 during those wr_en cycles. The first idle cycle gives ld_ready=1, ld_en=ld_be, and wr_addr ≠ 3.
5. Idle (wr_en=0), ld_valid with ld_addr_in=0 → ld_ready=1, wr_addr=1, load accepted with no stall.
6. rst_n low mid-ISSUE (k=1) → all enables, alu_valid, busy and done are 0 immediately. After release req_ready=1 and no done pulse appears.
